qsys_pio_gen: RTL and testbench



---
 rtl/qsys_pio_gen.sv | 159 +++++++++++++++
 tb/tb_qsys_pio_gen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qsys_pio_gen.sv
// Parametrised Avalon-MM GPIO: per-bit direction, atomic set/clear, synchronised inputs with edge capture and IRQ.
// Optional output blink engine on addresses 6/7 when QSYS_PIO_GEN_BLINK_EN is defined.
module qsys_pio_gen #(
    parameter int unsigned       WIDTH       = 8,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
    parameter logic [WIDTH-1:0]  DIR_RESET   = '1,
    parameter int unsigned       EDGE_TYPE   = 0,
    parameter int unsigned       BLINK_CW    = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [31:0]      unused_wd;

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] cap_clr;

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = writedata;

    always_comb begin
        if (EDGE_TYPE == 0) begin
            edge_det = s2_q & ~prev_q;
        end else if (EDGE_TYPE == 1) begin
            edge_det = ~s2_q & prev_q;
        end else begin
            edge_det = s2_q ^ prev_q;
        end
    end

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        irq_mask_d = irq_mask_q;
        cap_clr    = '0;
        s1_d       = in_port;
        s2_d       = s1_q;
        prev_d     = s2_q;
        if (wr) begin
            case (address)
                3'd0:    data_out_d = wd;
                3'd1:    dir_d      = wd;
                3'd2:    irq_mask_d = wd;
                3'd3:    cap_clr    = wd;
                3'd4:    data_out_d = data_out_q | wd;
                3'd5:    data_out_d = data_out_q & ~wd;
                default: ;
            endcase
        end
        // Set is OR'ed in after the clear so a same-cycle detect survives a W1C.
        edge_capture_d = (edge_capture_q & ~cap_clr) | (edge_det & ~dir_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q     <= RESET_VALUE;
            dir_q          <= DIR_RESET;
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
            s1_q           <= '0;
            s2_q           <= '0;
            prev_q         <= '0;
        end else begin
            data_out_q     <= data_out_d;
            dir_q          <= dir_d;
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            prev_q         <= prev_d;
        end
    end

    assign oe  = dir_q;
    assign irq = |(edge_capture_q & irq_mask_q);

`ifdef QSYS_PIO_GEN_BLINK_EN
    logic [WIDTH-1:0]    blink_mask_q, blink_mask_d;
    logic [BLINK_CW-1:0] blink_period_q, blink_period_d;
    logic [BLINK_CW-1:0] cnt_q, cnt_d;
    logic                phase_q, phase_d;

    always_comb begin
        blink_mask_d   = blink_mask_q;
        blink_period_d = blink_period_q;
        cnt_d          = cnt_q + BLINK_CW'(1);
        phase_d        = phase_q;
        if (wr && address == 3'd6) begin
            blink_mask_d = wd;
        end
        if (wr && address == 3'd7) begin
            blink_period_d = writedata[BLINK_CW-1:0];
            cnt_d          = '0;
            phase_d        = 1'b0;
        end else if (blink_period_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == blink_period_q - BLINK_CW'(1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_mask_q   <= '0;
            blink_period_q <= '0;
            cnt_q          <= '0;
            phase_q        <= 1'b0;
        end else begin
            blink_mask_q   <= blink_mask_d;
            blink_period_q <= blink_period_d;
            cnt_q          <= cnt_d;
            phase_q        <= phase_d;
        end
    end

    assign out_port = data_out_q ^ (blink_mask_q & {WIDTH{phase_q}});
`else
    localparam int unsigned UNUSED_BLINK_CW = BLINK_CW;
    assign out_port = data_out_q;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            3'd0:    readdata = 32'((dir_q & data_out_q) | (~dir_q & s2_q));
            3'd1:    readdata = 32'(dir_q);
            3'd2:    readdata = 32'(irq_mask_q);
            3'd3:    readdata = 32'(edge_capture_q);
`ifdef QSYS_PIO_GEN_BLINK_EN
            3'd6:    readdata = 32'(blink_mask_q);
            3'd7:    readdata = 32'(blink_period_q);
`endif
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_qsys_pio_gen.sv
// Self-checking bench for qsys_pio_gen: directed steps then random traffic against a behavioural model.
// Blink checks are included when QSYS_PIO_GEN_BLINK_EN is defined.
`timescale 1ns/1ps
module tb_qsys_pio_gen;
    localparam int unsigned      W   = 8;
    localparam logic [W-1:0]     RV  = 8'hA5;
    localparam int unsigned      ET  = 0;
    localparam int unsigned      BCW = 24;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [2:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic [W-1:0]  in_port = '0;
    logic [W-1:0]  out_port;
    logic [W-1:0]  oe;
    logic          irq;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    qsys_pio_gen #(.WIDTH(W), .RESET_VALUE(RV), .DIR_RESET('1), .EDGE_TYPE(ET), .BLINK_CW(BCW)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq)
    );

    // Reference model: register values plus a short history of sampled inputs.
    // hist[2] = latest sample, hist[1] = synchronised value, hist[0] = previous synchronised value.
    logic [W-1:0] m_data, m_dir, m_mask, m_cap;
    logic [W-1:0] hist[$];
    logic [W-1:0] m_bmask;
    int unsigned  m_period, m_cnt;
    bit           m_phase;

    task automatic m_reset();
        m_data = RV; m_dir = '1; m_mask = '0; m_cap = '0;
        hist = '{W'(0), W'(0), W'(0)};
        m_bmask = '0; m_period = 0; m_cnt = 0; m_phase = 1'b0;
    endtask

    task automatic m_edge(input logic [2:0] a, input bit wr, input logic [31:0] wd, input logic [W-1:0] inp);
        logic [W-1:0] w, det, clr, nxt_cap;
        w = wd[W-1:0];
        det = '0;
        for (int i = 0; i < int'(W); i++) begin
            bit now_v, old_v;
            now_v = hist[1][i];
            old_v = hist[0][i];
            if (!m_dir[i]) begin
                if (ET == 0)      det[i] = now_v && !old_v;
                else if (ET == 1) det[i] = !now_v && old_v;
                else              det[i] = now_v != old_v;
            end
        end
        clr = (wr && a == 3'd3) ? w : '0;
        nxt_cap = (m_cap & ~clr) | det;
`ifdef QSYS_PIO_GEN_BLINK_EN
        if (wr && a == 3'd7) begin
            m_cnt = 0; m_phase = 1'b0;
        end else if (m_period == 0) begin
            m_cnt = 0; m_phase = 1'b0;
        end else if (m_cnt + 1 == m_period) begin
            m_cnt = 0; m_phase = !m_phase;
        end else begin
            m_cnt = m_cnt + 1;
        end
`endif
        if (wr) begin
            case (a)
                3'd0: m_data = w;
                3'd1: m_dir = w;
                3'd2: m_mask = w;
                3'd4: m_data = m_data | w;
                3'd5: m_data = m_data & ~w;
`ifdef QSYS_PIO_GEN_BLINK_EN
                3'd6: m_bmask = w;
                3'd7: m_period = wd % (1 << BCW);
`endif
                default: ;
            endcase
        end
        m_cap = nxt_cap;
        hist.push_back(inp);
        void'(hist.pop_front());
    endtask

    function automatic logic [31:0] exp_rd(input logic [2:0] a);
        logic [W-1:0] v;
        v = '0;
        case (a)
            3'd0: for (int i = 0; i < int'(W); i++) v[i] = m_dir[i] ? m_data[i] : hist[1][i];
            3'd1: v = m_dir;
            3'd2: v = m_mask;
            3'd3: v = m_cap;
            default: v = '0;
        endcase
`ifdef QSYS_PIO_GEN_BLINK_EN
        if (a == 3'd6) return 32'(m_bmask);
        if (a == 3'd7) return 32'(m_period);
`endif
        return 32'(v);
    endfunction

    function automatic logic [W-1:0] exp_out();
        return m_data ^ (m_phase ? m_bmask : W'(0));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_cycle(input logic [2:0] a, input bit cs, input bit wr, input logic [31:0] wd, input logic [W-1:0] inp);
        @(negedge clk);
        address = a; chipselect = cs; write_n = !wr; writedata = wd; in_port = inp;
        #1;
        chk("readdata", readdata, exp_rd(a));
        chk("out_port", 32'(out_port), 32'(exp_out()));
        chk("oe", 32'(oe), 32'(m_dir));
        chk("irq", 32'(irq), 32'(|(m_cap & m_mask)));
        @(posedge clk);
        m_edge(a, cs && wr, wd, inp);
    endtask

    task automatic peek_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        #1;
        write_n = 1'b1; address = a;
        #1;
        chk(tag, readdata, exp);
    endtask

    task automatic release_reset();
        @(negedge clk);
        write_n = 1'b1; chipselect = 1'b0; reset_n = 1'b1;
        @(posedge clk);
        m_edge(address, 1'b0, '0, in_port);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rin;
        m_reset();
        #12;
        chk("rst_out_port", 32'(out_port), 32'h0000_00A5);
        chk("rst_oe", 32'(oe), 32'h0000_00FF);
        chk("rst_irq", 32'(irq), 32'h0);
        peek_chk("rst_cap", 3'd3, 32'h0);
        release_reset();

        // Data, set and clear
        do_cycle(3'd0, 1, 1, 32'hFFFF_FF0F, '0);
        #1 chk("data_wr", 32'(out_port), 32'h0F);
        do_cycle(3'd4, 1, 1, 32'h30, '0);
        #1 chk("outset", 32'(out_port), 32'h3F);
        do_cycle(3'd5, 1, 1, 32'h01, '0);
        #1 chk("outclear", 32'(out_port), 32'h3E);
        peek_chk("rd_outset", 3'd4, 32'h0);
        peek_chk("rd_outclr", 3'd5, 32'h0);

        // Capture latency: change before edge k, visible after edge k+2
        do_cycle(3'd1, 1, 1, 32'h0F, '0);
        do_cycle(3'd2, 1, 1, 32'h10, '0);
        for (int i = 0; i < 3; i++) do_cycle(3'd3, 1, 0, '0, '0);
        do_cycle(3'd3, 1, 0, '0, 8'h10);
        peek_chk("cap_k", 3'd3, 32'h0);
        do_cycle(3'd3, 1, 0, '0, 8'h10);
        peek_chk("cap_k1", 3'd3, 32'h0);
        do_cycle(3'd3, 1, 0, '0, 8'h10);
        peek_chk("cap_k2", 3'd3, 32'h10);
        chk("irq_set", 32'(irq), 32'h1);
        do_cycle(3'd3, 1, 1, 32'h10, 8'h10);
        peek_chk("cap_w1c", 3'd3, 32'h0);
        chk("irq_clr", 32'(irq), 32'h0);

        // Output bit edge is not captured
        for (int i = 0; i < 4; i++) do_cycle(3'd0, 1, 0, '0, 8'h11);
        peek_chk("cap_outbit", 3'd3, 32'h0);

        // Same-cycle detect and clear on bit 4: set wins
        for (int i = 0; i < 3; i++) do_cycle(3'd0, 1, 0, '0, 8'h01);
        peek_chk("cap_fall", 3'd3, 32'h0);
        do_cycle(3'd0, 1, 0, '0, 8'h11);
        do_cycle(3'd0, 1, 0, '0, 8'h11);
        do_cycle(3'd3, 1, 1, 32'h10, 8'h11);
        peek_chk("cap_setwins", 3'd3, 32'h10);
        chk("irq_setwins", 32'(irq), 32'h1);

        // Asynchronous reset mid-cycle
        #2;
        reset_n = 1'b0;
        m_reset();
        #1;
        chk("async_irq", 32'(irq), 32'h0);
        chk("async_out", 32'(out_port), 32'hA5);
        peek_chk("async_cap", 3'd3, 32'h0);
        in_port = '0;
        release_reset();

`ifdef QSYS_PIO_GEN_BLINK_EN
        do_cycle(3'd0, 1, 1, 32'h0, '0);
        do_cycle(3'd6, 1, 1, 32'h01, '0);
        do_cycle(3'd7, 1, 1, 32'h4, '0);
        for (int i = 0; i < 12; i++) do_cycle(3'd0, 1, 0, '0, '0);
        do_cycle(3'd7, 1, 1, 32'h0, '0);
        for (int i = 0; i < 6; i++) begin
            do_cycle(3'd0, 1, 0, '0, '0);
            #1 chk("blink_halt", 32'(out_port[0]), 32'h0);
        end
`else
        peek_chk("addr6_zero", 3'd6, 32'h0);
        peek_chk("addr7_zero", 3'd7, 32'h0);
`endif

        // Random traffic
        rin = '0;
        for (int n = 0; n < 400; n++) begin
            logic [2:0]  a;
            logic [31:0] wd;
            bit          cs, wr;
            a  = 3'($urandom_range(0, 7));
            cs = ($urandom_range(0, 7) != 0);
            wr = ($urandom_range(0, 2) != 0);
            wd = $urandom;
            if (a == 3'd7) wd = $urandom_range(0, 6);
            if ($urandom_range(0, 3) == 0) rin = W'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                #3;
                reset_n = 1'b0;
                m_reset();
                #1 chk("rand_rst_irq", 32'(irq), 32'h0);
                release_reset();
            end
            do_cycle(a, cs, wr, wd, rin);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
